ir_tx_sched: RTL and testbench

- Arbitrates and sequences the shared NEC IR transmitter (`ir_send`) between N_REQ independent requesters, each presenting an 8-bit address and 8-bit command.
- Grants one requester at a time, round-robin.
- Drives the transmitter's addr/cmd/start inputs and holds them stable for one full NEC frame period.
- Enforces the NEC frame spacing before the next grant. Sits between application logic (buttons, UART command decoder) and `ir_send`.

---
 rtl/ir_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/ir_tx_sched.sv | 91 +++++++++
 tb/tb_ir_tx_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared NEC IR definitions: protocol timing in microseconds, a us-to-clock
// conversion, and the transmit scheduler state encoding.
package ir_pkg;

  localparam int NEC_AGC_US          = 9000;
  localparam int NEC_SPACE_US        = 4500;
  localparam int NEC_REPEAT_SPACE_US = 2250;
  localparam int NEC_BIT_MARK_US     = 560;
  localparam int NEC_ONE_SPACE_US    = 1690;
  localparam int NEC_ZERO_SPACE_US   = 560;
  localparam int NEC_FRAME_US        = 108000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] cmd;
  } nec_req_t;

  // Integer MHz first so the product stays within 32 bits for NEC periods.
  function automatic int us_to_cycles(input int clk_hz, input int us);
    return (clk_hz / 1000000) * us;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request scanning upward from
// ptr with wrap-around. Shared with the receive-side dispatcher.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  logic          found;
  logic [PW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = PW'((int'(ptr) + i) % N_REQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/ir_tx_sched.sv
// Round-robin scheduler for the shared NEC transmitter: latches one
// requester's addr/cmd, fires ir_send, and holds off for one frame period.
module ir_tx_sched import ir_pkg::*; #(
  parameter int N_REQ        = 4,
  parameter int CLK_HZ       = 100000000,
  parameter int FRAME_US     = NEC_FRAME_US,
  parameter int FRAME_CYCLES = us_to_cycles(CLK_HZ, FRAME_US)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_cmd,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         tx_addr,
  output logic [7:0]         tx_cmd,
  output logic               tx_start,
  output logic               busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(FRAME_CYCLES);

  if (FRAME_CYCLES < 4 || N_REQ < 2 || N_REQ > 8) begin : g_param_err
    $error("ir_tx_sched: FRAME_CYCLES must be >= 4 and N_REQ in 2..8");
  end

  logic [1:0]                state;
  logic [CW-1:0]             cnt;
  logic [PW-1:0]             ptr, win_idx, arb_idx;
  logic [N_REQ-1:0]          win_oh, arb_oh;
  logic                      arb_vld;
  logic [N_REQ-1:0][7:0]     addr_v, cmd_v;
  nec_req_t                  frame;

  assign addr_v = req_addr;
  assign cmd_v  = req_cmd;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_oh),
    .idx   (arb_idx),
    .valid (arb_vld)
  );

  // LOAD + (FRAME_CYCLES-2) FRAME cycles + DONE = FRAME_CYCLES total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ptr     <= '0;
      win_idx <= '0;
      win_oh  <= '0;
      frame   <= '0;
    end else begin
      case (state)
        S_IDLE: if (en && arb_vld) begin
          win_oh     <= arb_oh;
          win_idx    <= arb_idx;
          frame.addr <= addr_v[arb_idx];
          frame.cmd  <= cmd_v[arb_idx];
          state      <= S_LOAD;
        end
        S_LOAD: begin
          cnt   <= CW'(FRAME_CYCLES - 3);
          state <= S_FRAME;
        end
        S_FRAME: begin
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        S_DONE: begin
          ptr   <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign tx_addr  = frame.addr;
  assign tx_cmd   = frame.cmd;
  assign tx_start = (state == S_LOAD);
  assign grant    = tx_start ? win_oh : '0;
  assign done     = (state == S_DONE) ? win_oh : '0;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_ir_tx_sched.sv
// Directed scoreboard bench for ir_tx_sched (N_REQ=4, FRAME_CYCLES=20):
// stimulus queues expected frames, a negedge monitor checks what appears.
module tb_ir_tx_sched;

  localparam int N = 4;
  localparam int F = 20;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_cmd  = '0;
  logic [N-1:0]   grant, done;
  logic [7:0]     tx_addr, tx_cmd;
  logic           tx_start, busy;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         c;
    logic [N-1:0] g;
    logic [7:0] a;
    logic [7:0] m;
  } exp_t;

  exp_t start_q[$];
  exp_t done_q[$];
  exp_t cur, dexp;
  bit   in_frame = 1'b0;
  int   run = 0;

  ir_tx_sched #(.N_REQ(N), .FRAME_CYCLES(F)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .req_addr (req_addr),
    .req_cmd  (req_cmd),
    .grant    (grant),
    .done     (done),
    .tx_addr  (tx_addr),
    .tx_cmd   (tx_cmd),
    .tx_start (tx_start),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input logic [7:0] a, input logic [7:0] m);
    req_addr[8*i +: 8] = a;
    req_cmd[8*i +: 8]  = m;
  endtask

  task automatic expect_frame(input int c, input logic [N-1:0] g,
                              input logic [7:0] a, input logic [7:0] m);
    exp_t e;
    e.c = c; e.g = g; e.a = a; e.m = m;
    start_q.push_back(e);
    e.c = c + F - 1;
    done_q.push_back(e);
  endtask

  // Asserts reset asynchronously, checks outputs cleared with no clock edge,
  // then releases one tick-aligned instant (posedge + 1).
  task automatic do_reset(input bit drained);
    if (drained) chk("queues_drained", 32'(start_q.size() + done_q.size()), 32'd0);
    req = '0;
    rst = 1'b0;
    #2;
    chk("rst_grant",    32'(grant),    32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tx_addr",  32'(tx_addr),  32'd0);
    chk("rst_tx_cmd",   32'(tx_cmd),   32'd0);
    start_q.delete();
    done_q.delete();
    tick(2);
    rst = 1'b1;
  endtask

  // Monitor: pops expectations when the DUT presents a start or done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      run      = 0;
      in_frame = 1'b0;
    end else begin
      if (tx_start) begin
        if (start_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else begin
          cur      = start_q.pop_front();
          in_frame = 1'b1;
          chk("start_cyc", 32'(cyc), 32'(cur.c));
          chk("grant", 32'(grant), 32'(cur.g));
        end
      end else if (grant != '0) chk("grant_no_start", 32'(grant), 32'd0);
      if (in_frame) begin
        chk("tx_addr", 32'(tx_addr), 32'(cur.a));
        chk("tx_cmd",  32'(tx_cmd),  32'(cur.m));
      end
      if (done != '0) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          dexp = done_q.pop_front();
          chk("done_cyc", 32'(cyc), 32'(dexp.c));
          chk("done", 32'(done), 32'(dexp.g));
        end
      end
      if (busy) run++;
      else begin
        if (run != 0) chk("busy_len", 32'(run), 32'(F));
        run = 0;
      end
    end
  end

  initial begin
    int t;
    #1;
    do_reset(1'b0);

    // Single request from requester 0.
    set_rq(0, 8'h10, 8'hD8);
    req = 4'b0001; t = cyc;
    expect_frame(t + 1, 4'b0001, 8'h10, 8'hD8);
    tick(1); req = '0;
    tick(25);

    // All four from reset: strict rotation, 21 cycles apart.
    do_reset(1'b1);
    for (int i = 0; i < N; i++) set_rq(i, 8'(8'h20 + i), 8'(8'hA0 + i));
    req = 4'b1111; t = cyc;
    expect_frame(t + 1,  4'b0001, 8'h20, 8'hA0);
    expect_frame(t + 22, 4'b0010, 8'h21, 8'hA1);
    expect_frame(t + 43, 4'b0100, 8'h22, 8'hA2);
    expect_frame(t + 64, 4'b1000, 8'h23, 8'hA3);
    expect_frame(t + 85, 4'b0001, 8'h20, 8'hA0);
    tick(85); req = '0;
    tick(25);

    // Inputs change mid-frame: latched values hold, no regrant.
    set_rq(0, 8'h10, 8'hD8);
    req = 4'b0001; t = cyc;
    expect_frame(t + 1, 4'b0001, 8'h10, 8'hD8);
    tick(5);
    set_rq(0, 8'h10, 8'h55); req = '0;
    tick(30);

    // en drops mid-frame; next grant waits for en.
    set_rq(1, 8'h31, 8'h62);
    set_rq(2, 8'h42, 8'h84);
    req = 4'b0010; t = cyc;
    expect_frame(t + 1, 4'b0010, 8'h31, 8'h62);
    tick(5); en = 1'b0; req = 4'b0100;
    tick(25); en = 1'b1;
    expect_frame(t + 31, 4'b0100, 8'h42, 8'h84);
    tick(1); req = '0;
    tick(25);

    // Reset on cycle 10 of a frame: no done, pointer back to 0.
    set_rq(3, 8'h5A, 8'hC3);
    req = 4'b1000; t = cyc;
    expect_frame(t + 1, 4'b1000, 8'h5A, 8'hC3);
    tick(10);
    do_reset(1'b0);
    req = 4'b0100; t = cyc;
    expect_frame(t + 1, 4'b0100, 8'h42, 8'h84);
    tick(1); req = '0;
    tick(25);

    // Rotation after partial service: 1, then 3, 0, 1.
    set_rq(0, 8'h10, 8'hD8);
    req = 4'b0010; t = cyc;
    expect_frame(t + 1,  4'b0010, 8'h31, 8'h62);
    expect_frame(t + 22, 4'b1000, 8'h5A, 8'hC3);
    expect_frame(t + 43, 4'b0001, 8'h10, 8'hD8);
    expect_frame(t + 64, 4'b0010, 8'h31, 8'h62);
    tick(1);  req = 4'b1011;
    tick(21); req = 4'b0011;
    tick(21); req = 4'b0010;
    tick(21); req = '0;
    tick(25);

    chk("start_q_empty", 32'(start_q.size()), 32'd0);
    chk("done_q_empty",  32'(done_q.size()),  32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
